ads8684_ctrl: RTL and testbench



---
 rtl/ads8684_ctrl_if.sv | 49 ++++
 rtl/ads8684_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_ads8684_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads8684_ctrl_if.sv
// ----------------------------------------------------------------------------
// ads8684_ctrl_if
// Purpose : groups the request/result handshake and the ADS8684 SPI pins of
//           ads8684_ctrl into one bundle.
// Signals : req, req_ch          - conversion request and its channel (0..3)
//           req_ready            - command slot empty, request can be taken
//           data_valid, data,
//           data_ch              - one-cycle result pulse, 16-bit result, channel
//           busy                 - controller is not idle
//           csn, sclk, sdi, sdo  - ADS8684 serial port
//           scan_en              - auto-scan enable, present only when
//                                  ADS8684_CTRL_AUTO_SCAN_EN is defined
// Modports: slave  - the controller side
//           master - the requester / ADC side
// ----------------------------------------------------------------------------
interface ads8684_ctrl_if;
  logic        req;
  logic [1:0]  req_ch;
  logic        req_ready;
  logic        data_valid;
  logic [15:0] data;
  logic [1:0]  data_ch;
  logic        busy;
  logic        csn;
  logic        sclk;
  logic        sdi;
  logic        sdo;
`ifdef ADS8684_CTRL_AUTO_SCAN_EN
  logic        scan_en;

  modport slave (
    input  req, req_ch, sdo, scan_en,
    output req_ready, data_valid, data, data_ch, busy, csn, sclk, sdi
  );
  modport master (
    output req, req_ch, sdo, scan_en,
    input  req_ready, data_valid, data, data_ch, busy, csn, sclk, sdi
  );
`else
  modport slave (
    input  req, req_ch, sdo,
    output req_ready, data_valid, data, data_ch, busy, csn, sclk, sdi
  );
  modport master (
    output req, req_ch, sdo,
    input  req_ready, data_valid, data, data_ch, busy, csn, sclk, sdi
  );
`endif
endinterface

// File: rtl/ads8684_ctrl.sv
// ----------------------------------------------------------------------------
// ads8684_ctrl
// Purpose : drives an ADS8684 ADC with 32-bit SPI frames. Each frame carries a
//           manual-channel-select command (or NO_OP) in its top 16 bits; the
//           ADC answers a command one frame later, so the result of a command
//           frame is returned at the end of the following frame.
// Params  : SCLK_DIV - clk cycles per sclk half-period (1..255)
//           CS_GAP   - clk cycles csn stays high between frames (1..255)
// Ports   : clk  - clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - ads8684_ctrl_if.slave (request, result and SPI signals)
// Option  : ADS8684_CTRL_AUTO_SCAN_EN adds bus.scan_en; while it is high the
//           controller queues channels 0,1,2,3,0,... by itself.
// ----------------------------------------------------------------------------
module ads8684_ctrl #(
  parameter int SCLK_DIV = 2,
  parameter int CS_GAP   = 4
) (
  input  logic          clk,
  input  logic          rst,
  ads8684_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state_reg, state_next;
  logic        slot_full_reg, slot_full_next;
  logic [1:0]  slot_ch_reg, slot_ch_next;
  logic        cur_cmd_reg, cur_cmd_next;        // frame on the wire is a command
  logic [1:0]  cur_ch_reg, cur_ch_next;
  logic        inflight_valid_reg, inflight_valid_next;
  logic [1:0]  inflight_ch_reg, inflight_ch_next;
  logic [30:0] tx_reg, tx_next;                  // bits still to go after sdi
  logic [14:0] rx_reg, rx_next;                  // only the low 16 bits matter
  logic [7:0]  div_cnt_reg, div_cnt_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic        csn_reg, csn_next;
  logic        sclk_reg, sclk_next;
  logic        sdi_reg, sdi_next;
  logic        data_valid_reg, data_valid_next;
  logic [15:0] data_reg, data_next;
  logic [1:0]  data_ch_reg, data_ch_next;

  logic        req_ready;
  logic        accept;
  logic        start_frame;
  logic [31:0] frame_word;

`ifdef ADS8684_CTRL_AUTO_SCAN_EN
  logic        scan_en_d_reg, scan_en_d_next;
  logic [1:0]  scan_ch_reg, scan_ch_next;
  logic        scan_rise;
  logic [1:0]  scan_fill_ch;

  assign scan_rise    = bus.scan_en && !scan_en_d_reg;
  // A fresh scan always begins at channel 0.
  assign scan_fill_ch = scan_rise ? 2'd0 : scan_ch_reg;
  assign req_ready    = !slot_full_reg && !bus.scan_en;
`else
  assign req_ready    = !slot_full_reg;
`endif

  assign accept = bus.req && req_ready;

  // Word loaded at frame start: command for the slot channel, or NO_OP.
  always_comb begin
    frame_word = 32'h0;
    if (slot_full_reg) begin
      frame_word = {4'b1100, slot_ch_reg, 26'h0};
    end
  end

  always_comb begin
    state_next          = state_reg;
    slot_full_next      = slot_full_reg;
    slot_ch_next        = slot_ch_reg;
    cur_cmd_next        = cur_cmd_reg;
    cur_ch_next         = cur_ch_reg;
    inflight_valid_next = inflight_valid_reg;
    inflight_ch_next    = inflight_ch_reg;
    tx_next             = tx_reg;
    rx_next             = rx_reg;
    div_cnt_next        = div_cnt_reg;
    bit_cnt_next        = bit_cnt_reg;
    gap_cnt_next        = gap_cnt_reg;
    csn_next            = csn_reg;
    sclk_next           = sclk_reg;
    sdi_next            = sdi_reg;
    data_valid_next     = 1'b0;
    data_next           = data_reg;
    data_ch_next        = data_ch_reg;
    start_frame         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (slot_full_reg) begin
          start_frame = 1'b1;
        end
      end

      SHIFT: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = 8'd0;
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else begin
            // sclk returns low: sample sdo, then either move on or close.
            sclk_next = 1'b0;
            rx_next   = {rx_reg[13:0], bus.sdo};
            if (bit_cnt_reg == 5'd31) begin
              state_next   = GAP;
              csn_next     = 1'b1;
              sdi_next     = 1'b0;
              gap_cnt_next = 8'd0;
              if (inflight_valid_reg) begin
                data_valid_next = 1'b1;
                data_next       = {rx_reg, bus.sdo};
                data_ch_next    = inflight_ch_reg;
              end
              inflight_valid_next = cur_cmd_reg;
              inflight_ch_next    = cur_ch_reg;
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
              sdi_next     = tx_reg[30];
              tx_next      = {tx_reg[29:0], 1'b0};
            end
          end
        end else begin
          div_cnt_next = div_cnt_reg + 8'd1;
        end
      end

      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          // An outstanding result needs one more frame to come back.
          if (slot_full_reg || inflight_valid_reg) begin
            start_frame = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase

    if (start_frame) begin
      state_next     = SHIFT;
      csn_next       = 1'b0;
      sclk_next      = 1'b0;
      div_cnt_next   = 8'd0;
      bit_cnt_next   = 5'd0;
      sdi_next       = frame_word[31];
      tx_next        = frame_word[30:0];
      cur_cmd_next   = slot_full_reg;
      cur_ch_next    = slot_ch_reg;
      slot_full_next = 1'b0;
    end

    // Filling only ever happens into an empty slot, so it may coincide with
    // a NO_OP frame start and must win over the clear above.
    if (accept) begin
      slot_full_next = 1'b1;
      slot_ch_next   = bus.req_ch;
    end

`ifdef ADS8684_CTRL_AUTO_SCAN_EN
    scan_en_d_next = bus.scan_en;
    scan_ch_next   = scan_ch_reg;
    if (bus.scan_en) begin
      if (!slot_full_reg) begin
        slot_full_next = 1'b1;
        slot_ch_next   = scan_fill_ch;
        scan_ch_next   = scan_fill_ch + 2'd1;
      end else if (scan_rise) begin
        scan_ch_next = 2'd0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      slot_full_reg      <= 1'b0;
      slot_ch_reg        <= 2'd0;
      cur_cmd_reg        <= 1'b0;
      cur_ch_reg         <= 2'd0;
      inflight_valid_reg <= 1'b0;
      inflight_ch_reg    <= 2'd0;
      tx_reg             <= 31'h0;
      rx_reg             <= 15'h0;
      div_cnt_reg        <= 8'd0;
      bit_cnt_reg        <= 5'd0;
      gap_cnt_reg        <= 8'd0;
      csn_reg            <= 1'b1;
      sclk_reg           <= 1'b0;
      sdi_reg            <= 1'b0;
      data_valid_reg     <= 1'b0;
      data_reg           <= 16'h0;
      data_ch_reg        <= 2'd0;
`ifdef ADS8684_CTRL_AUTO_SCAN_EN
      scan_en_d_reg      <= 1'b0;
      scan_ch_reg        <= 2'd0;
`endif
    end else begin
      state_reg          <= state_next;
      slot_full_reg      <= slot_full_next;
      slot_ch_reg        <= slot_ch_next;
      cur_cmd_reg        <= cur_cmd_next;
      cur_ch_reg         <= cur_ch_next;
      inflight_valid_reg <= inflight_valid_next;
      inflight_ch_reg    <= inflight_ch_next;
      tx_reg             <= tx_next;
      rx_reg             <= rx_next;
      div_cnt_reg        <= div_cnt_next;
      bit_cnt_reg        <= bit_cnt_next;
      gap_cnt_reg        <= gap_cnt_next;
      csn_reg            <= csn_next;
      sclk_reg           <= sclk_next;
      sdi_reg            <= sdi_next;
      data_valid_reg     <= data_valid_next;
      data_reg           <= data_next;
      data_ch_reg        <= data_ch_next;
`ifdef ADS8684_CTRL_AUTO_SCAN_EN
      scan_en_d_reg      <= scan_en_d_next;
      scan_ch_reg        <= scan_ch_next;
`endif
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.csn        = csn_reg;
  assign bus.sclk       = sclk_reg;
  assign bus.sdi        = sdi_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.data       = data_reg;
  assign bus.data_ch    = data_ch_reg;

endmodule

// File: tb/tb_ads8684_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ads8684_ctrl
// Purpose : self-checking bench for ads8684_ctrl. An ADC model answers each
//           frame with the input value of the channel commanded in the frame
//           before; a monitor records every frame and every result, and each
//           burst is checked against the list of accepted channels.
// Option  : ADS8684_CTRL_AUTO_SCAN_EN enables the auto-scan step.
// ----------------------------------------------------------------------------
module tb_ads8684_ctrl;
  localparam int SCLK_DIV = 2;
  localparam int CS_GAP   = 4;

  typedef struct {
    logic [31:0] cmd;
    int          low;
    int          rises;
    int          gap;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ads8684_ctrl_if bus();

  ads8684_ctrl #(.SCLK_DIV(SCLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] ain [4];
  frame_t      frames[$];
  logic [17:0] results[$];
  logic [1:0]  exp_ch[$];
  int          hold_cycles = 0;

  // Monitor and ADC model, all on the falling clk edge.
  int          cur_low = 0, cur_rises = 0, gap_cnt = 1000, start_gap = 0;
  int          starts = 0, sclk_bad = 0;
  logic [31:0] cur_word = 0, adc_word = 0;
  logic        csn_p = 1'b1, sclk_p = 1'b0;
  logic        last_valid = 1'b0;
  logic [1:0]  last_ch = 2'd0;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) results.push_back({bus.data_ch, bus.data});
    if (bus.csn === 1'b0 && csn_p === 1'b1) begin
      starts++;
      cur_low   = 0;
      cur_rises = 0;
      cur_word  = 32'h0;
      start_gap = gap_cnt;
      adc_word  = {16'($urandom), last_valid ? ain[last_ch] : 16'h0000};
      bus.sdo   = 1'b0;
    end
    if (bus.csn === 1'b0) begin
      cur_low++;
      if (bus.sclk === 1'b1 && sclk_p === 1'b0) begin
        cur_word = {cur_word[30:0], bus.sdi};
        if (cur_rises < 32) bus.sdo = adc_word[31 - cur_rises];
        cur_rises++;
      end
    end else begin
      if (bus.sclk !== 1'b0) sclk_bad++;
      if (csn_p === 1'b0) begin
        frames.push_back('{cmd: cur_word, low: cur_low, rises: cur_rises, gap: start_gap});
        // An aborted frame leaves nothing for the ADC to answer.
        last_valid = (cur_rises == 32) && (cur_word[31:30] == 2'b11);
        last_ch    = cur_word[27:26];
        gap_cnt    = 1;
      end else begin
        gap_cnt++;
      end
    end
    csn_p  = bus.csn;
    sclk_p = bus.sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    frames.delete();
    results.delete();
    exp_ch.delete();
  endtask

  task automatic do_req(input logic [1:0] ch);
    int t = 0;
    @(negedge clk);
    bus.req    = 1'b1;
    bus.req_ch = ch;
    while (bus.req_ready !== 1'b1 && t < 5000) begin
      hold_cycles++;
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check("req_accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    bus.req    = 1'b0;
    bus.req_ch = 2'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (2) @(negedge clk);
    while (!(bus.busy === 1'b0 && bus.req_ready === 1'b1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) check("idle_timeout", 32'(t), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // A burst of accepted channels must give one command frame per channel,
  // one trailing NO_OP, and one result per channel, in order.
  task automatic check_burst(input string tag);
    int n;
    logic [31:0] ew;
    n = exp_ch.size();
    check({tag, "_nframes"}, 32'(frames.size()), 32'(n + 1));
    check({tag, "_nresults"}, 32'(results.size()), 32'(n));
    for (int i = 0; i <= n && i < frames.size(); i++) begin
      ew = (i < n) ? {4'b1100, exp_ch[i], 26'h0} : 32'h0;
      check($sformatf("%s_cmd%0d", tag, i), frames[i].cmd, ew);
      check($sformatf("%s_low%0d", tag, i), 32'(frames[i].low), 32'(64 * SCLK_DIV));
      check($sformatf("%s_sclk%0d", tag, i), 32'(frames[i].rises), 32'd32);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'(frames[i].gap), 32'(CS_GAP));
    end
    for (int i = 0; i < n && i < results.size(); i++) begin
      check($sformatf("%s_res%0d", tag, i), 32'(results[i]), 32'({exp_ch[i], ain[exp_ch[i]]}));
    end
  endtask

  initial begin
    int t;
    int n;
    logic [1:0] ch;
    bus.req    = 1'b0;
    bus.req_ch = 2'd0;
`ifdef ADS8684_CTRL_AUTO_SCAN_EN
    bus.scan_en = 1'b0;
`endif
    for (int i = 0; i < 4; i++) ain[i] = 16'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(bus.csn), 32'd1);
    check("rst_sclk", 32'(bus.sclk), 32'd0);
    check("rst_sdi", 32'(bus.sdi), 32'd0);
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_data_ch", 32'(bus.data_ch), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;
    $display("step: reset released");

    // Single read of channel 0
    repeat (3) @(negedge clk);
    clear_logs();
    ain[0] = 16'hCAFE;
    exp_ch.push_back(2'd0);
    do_req(2'd0);
    check("single_ready_after_accept", 32'(bus.req_ready), 32'd0);
    wait_idle();
    check_burst("single");
    $display("step: single read ch0 done");

    // Back-to-back, second request taken during the first frame
    clear_logs();
    ain[1] = 16'h1234;
    ain[3] = 16'hABCD;
    exp_ch.push_back(2'd1);
    exp_ch.push_back(2'd3);
    do_req(2'd1);
    t = 0;
    while (bus.csn !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    check("b2b_busy_in_frame", 32'(bus.busy), 32'd1);
    do_req(2'd3);
    wait_idle();
    check_burst("b2b");
    $display("step: back-to-back ch1, ch3 done");

    // Random bursts with req held while the slot is full
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      hold_cycles = 0;
      for (int i = 0; i < 4; i++) ain[i] = 16'($urandom);
      n = $urandom_range(3, 5);
      for (int k = 0; k < n; k++) begin
        ch = 2'($urandom);
        exp_ch.push_back(ch);
        do_req(ch);
      end
      wait_idle();
      check_burst($sformatf("burst%0d", r));
      check($sformatf("burst%0d_held", r), 32'(hold_cycles > 0), 32'd1);
      $display("step: random burst %0d of %0d requests done", r, n);
    end

    // Reset in the middle of a channel 2 command frame
    clear_logs();
    for (int i = 0; i < 4; i++) ain[i] = 16'($urandom);
    do_req(2'd2);
    t = 0;
    while (cur_rises < 10 && t < 1000) begin @(negedge clk); t++; end
    check("rst_mid_reached_bit10", 32'(cur_rises >= 10), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_csn", 32'(bus.csn), 32'd1);
    check("rst_mid_sclk", 32'(bus.sclk), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_mid_no_result", 32'(results.size()), 32'd0);
    clear_logs();
    exp_ch.push_back(2'd0);
    do_req(2'd0);
    wait_idle();
    check_burst("post_rst");
    $display("step: reset mid-frame and recovery done");

`ifdef ADS8684_CTRL_AUTO_SCAN_EN
    // Auto-scan for five frames
    clear_logs();
    for (int i = 0; i < 4; i++) ain[i] = 16'($urandom);
    n = starts;
    bus.scan_en = 1'b1;
    repeat (2) @(negedge clk);
    check("scan_ready_low", 32'(bus.req_ready), 32'd0);
    t = 0;
    while (starts < n + 5 && t < 5000) begin @(negedge clk); t++; end
    check("scan_five_frames", 32'(starts >= n + 5), 32'd1);
    bus.scan_en = 1'b0;
    wait_idle();
    for (int i = 0; i < 5 && i < frames.size(); i++) begin
      check($sformatf("scan_cmd%0d", i), frames[i].cmd, {4'b1100, 2'(i), 26'h0});
    end
    check("scan_nframes", 32'(frames.size() >= 5), 32'd1);
    check("scan_nresults", 32'(results.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < results.size(); i++) begin
      check($sformatf("scan_res%0d", i), 32'(results[i]), 32'({2'(i), ain[i]}));
    end
    $display("step: auto-scan done");
`endif

    check("sclk_low_when_csn_high", 32'(sclk_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
